// File: rtl/hazard_scoreboard.sv
// Register-write scoreboard: per-register in-flight write counters and the
// decode-stage stall signal, with a same-cycle retire bypass.
module hazard_scoreboard #(
  parameter int NUM_REGS  = 16,
  parameter int CNT_WIDTH = 2,
  parameter int PC_REG    = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic [3:0]          src1,
  input  logic [3:0]          src2,
  input  logic                twoSrc,
  input  logic                srcValid,
  input  logic                issue,
  input  logic                issueWritebackEnabled,
  input  logic [3:0]          issueDestination,
  input  logic                writebackEnabled,
  input  logic [3:0]          writebackDestination,
  output logic                hazard,
  output logic [NUM_REGS-1:0] pendingMask,
  output logic                error
);

  typedef logic [CNT_WIDTH-1:0] cnt_t;
  localparam cnt_t CNT_MAX = '1;

  cnt_t                cnt     [NUM_REGS];
  cnt_t                cnt_nxt [NUM_REGS];
  logic [NUM_REGS-1:0] inc;
  logic [NUM_REGS-1:0] dec;
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] err_vec;
  logic [NUM_REGS-1:0] pend_nxt;
  logic [NUM_REGS-1:0] pend_q;
  logic                err_q;

  // Returns {fault, next count}; over/underflow holds the count and flags a fault.
  function automatic logic [CNT_WIDTH:0] step_cnt(input cnt_t c, input logic up,
                                                  input logic dn);
    logic [CNT_WIDTH:0] r;
    r = {1'b0, c};
    if (up && !dn) begin
      if (c == CNT_MAX) r = {1'b1, c};
      else              r = {1'b0, c + cnt_t'(1)};
    end else if (dn && !up) begin
      if (c == '0) r = {1'b1, c};
      else         r = {1'b0, c - cnt_t'(1)};
    end
    return r;
  endfunction

  always_comb begin
    inc      = '0;
    dec      = '0;
    busy     = '0;
    err_vec  = '0;
    pend_nxt = '0;
    cnt_nxt  = cnt;
    for (int i = 0; i < NUM_REGS; i++) begin
      inc[i] = issue & issueWritebackEnabled & (issueDestination == 4'(i)) & (i != PC_REG);
      dec[i] = writebackEnabled & (writebackDestination == 4'(i)) & (i != PC_REG);
      {err_vec[i], cnt_nxt[i]} = step_cnt(cnt[i], inc[i], dec[i]);
      // Flush wins over everything and is never itself a fault.
      if (clear) begin
        cnt_nxt[i] = '0;
        err_vec[i] = 1'b0;
      end
      pend_nxt[i] = |cnt_nxt[i];
      // A retiring write is already visible to decode through the falling-edge regfile write.
      busy[i] = (i != PC_REG) & (cnt[i] > cnt_t'(dec[i]));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
      pend_q <= '0;
      err_q  <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      pend_q <= pend_nxt;
      if (|err_vec) err_q <= 1'b1;
    end
  end

  assign hazard      = srcValid & (busy[src1] | (twoSrc & busy[src2]));
  assign pendingMask = pend_q;
  assign error       = err_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed vector table, async-reset sequences and
// randomized traffic against a counting reference model.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic [3:0]  src1, src2;
  logic        twoSrc, srcValid;
  logic        issue, issueWritebackEnabled;
  logic [3:0]  issueDestination;
  logic        writebackEnabled;
  logic [3:0]  writebackDestination;
  logic        hazard;
  logic [15:0] pendingMask;
  logic        error;

  int pass_cnt = 0;
  int total_cnt = 0;

  int mc [16];
  bit merr;

  hazard_scoreboard #(.NUM_REGS(16), .CNT_WIDTH(2), .PC_REG(15)) dut (
    .clk(clk), .rst(rst), .clear(clear), .src1(src1), .src2(src2),
    .twoSrc(twoSrc), .srcValid(srcValid), .issue(issue),
    .issueWritebackEnabled(issueWritebackEnabled),
    .issueDestination(issueDestination), .writebackEnabled(writebackEnabled),
    .writebackDestination(writebackDestination), .hazard(hazard),
    .pendingMask(pendingMask), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        clr, iss, iwe;
    logic [3:0]  idst;
    logic        we;
    logic [3:0]  wdst;
    logic        sv, two;
    logic [3:0]  s1, s2;
    logic        hz;
    logic [15:0] pm;
    logic        err;
  } vec_t;

  function automatic vec_t mk(logic clr, logic iss, logic iwe, logic [3:0] idst,
                              logic we, logic [3:0] wdst, logic sv, logic two,
                              logic [3:0] s1, logic [3:0] s2, logic hz,
                              logic [15:0] pm, logic err);
    vec_t v;
    v.clr = clr; v.iss = iss; v.iwe = iwe; v.idst = idst; v.we = we; v.wdst = wdst;
    v.sv = sv; v.two = two; v.s1 = s1; v.s2 = s2; v.hz = hz; v.pm = pm; v.err = err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input vec_t v);
    clear = v.clr; issue = v.iss; issueWritebackEnabled = v.iwe;
    issueDestination = v.idst; writebackEnabled = v.we; writebackDestination = v.wdst;
    srcValid = v.sv; twoSrc = v.two; src1 = v.s1; src2 = v.s2;
  endtask

  // Called just after a rising edge: check hazard before the next edge, outputs after it.
  task automatic apply(input vec_t v, input string tag);
    drive(v);
    #1 check({tag, ".hazard"}, 32'(hazard), 32'(v.hz));
    @(posedge clk); #1;
    check({tag, ".pendingMask"}, 32'(pendingMask), 32'(v.pm));
    check({tag, ".error"}, 32'(error), 32'(v.err));
  endtask

  function automatic bit m_busy(int r, bit we, int wd);
    int e;
    e = mc[r] - ((we && wd == r) ? 1 : 0);
    if (e < 0) e = 0;
    return (r != 15) && (e != 0);
  endfunction

  function automatic logic [15:0] m_mask();
    logic [15:0] m;
    for (int r = 0; r < 16; r++) m[r] = (mc[r] != 0);
    return m;
  endfunction

  task automatic m_reset();
    for (int r = 0; r < 16; r++) mc[r] = 0;
    merr = 1'b0;
  endtask

  task automatic m_update(input vec_t v);
    for (int r = 0; r < 16; r++) begin
      bit i, d;
      if (r == 15) continue;
      i = v.iss && v.iwe && (int'(v.idst) == r);
      d = v.we && (int'(v.wdst) == r);
      if (v.clr) mc[r] = 0;
      else if (i && d) mc[r] = mc[r];
      else if (i) begin
        if (mc[r] == 3) merr = 1'b1; else mc[r] = mc[r] + 1;
      end else if (d) begin
        if (mc[r] == 0) merr = 1'b1; else mc[r] = mc[r] - 1;
      end
    end
  endtask

  vec_t tbl [34];
  vec_t idle;
  vec_t rv;

  initial begin
    idle = mk(0,0,0,0, 0,0, 0,0,0,0, 0,16'h0000,0);
    tbl[0]  = mk(0,1,1,3,  0,0,  1,0,3,0,  0,16'h0008,0);
    tbl[1]  = mk(0,0,0,0,  0,0,  1,0,3,0,  1,16'h0008,0);
    tbl[2]  = mk(0,0,0,0,  0,0,  1,0,3,0,  1,16'h0008,0);
    tbl[3]  = mk(0,0,0,0,  1,3,  1,0,3,0,  0,16'h0000,0);
    tbl[4]  = mk(0,0,0,0,  0,0,  1,0,3,0,  0,16'h0000,0);
    tbl[5]  = mk(0,1,0,6,  0,0,  1,0,6,0,  0,16'h0000,0);
    tbl[6]  = mk(0,1,1,5,  0,0,  0,0,0,0,  0,16'h0020,0);
    tbl[7]  = mk(0,1,1,5,  0,0,  1,1,0,5,  1,16'h0020,0);
    tbl[8]  = mk(0,0,0,0,  1,5,  1,1,0,5,  1,16'h0020,0);
    tbl[9]  = mk(0,0,0,0,  1,5,  1,1,0,5,  0,16'h0000,0);
    tbl[10] = mk(0,1,1,5,  0,0,  0,0,0,0,  0,16'h0020,0);
    tbl[11] = mk(0,0,0,0,  0,0,  1,0,0,5,  0,16'h0020,0);
    tbl[12] = mk(0,0,0,0,  1,5,  1,0,0,5,  0,16'h0000,0);
    tbl[13] = mk(0,1,1,7,  0,0,  0,0,0,0,  0,16'h0080,0);
    tbl[14] = mk(0,1,1,7,  1,7,  1,0,7,0,  0,16'h0080,0);
    tbl[15] = mk(0,0,0,0,  0,0,  1,0,7,0,  1,16'h0080,0);
    tbl[16] = mk(0,0,0,0,  0,0,  0,0,7,0,  0,16'h0080,0);
    tbl[17] = mk(0,0,0,0,  1,7,  1,0,7,0,  0,16'h0000,0);
    tbl[18] = mk(0,1,1,2,  0,0,  0,0,0,0,  0,16'h0004,0);
    tbl[19] = mk(0,1,1,2,  0,0,  0,0,0,0,  0,16'h0004,0);
    tbl[20] = mk(0,1,1,2,  0,0,  0,0,0,0,  0,16'h0004,0);
    tbl[21] = mk(0,1,1,2,  0,0,  0,0,0,0,  0,16'h0004,1);
    tbl[22] = mk(0,0,0,0,  1,9,  1,0,9,0,  0,16'h0004,1);
    tbl[23] = mk(0,1,1,15, 1,15, 1,1,15,15, 0,16'h0004,1);
    tbl[24] = mk(0,0,0,0,  0,0,  1,0,2,0,  1,16'h0004,1);
    tbl[25] = mk(0,0,0,0,  1,2,  1,0,2,0,  1,16'h0004,1);
    tbl[26] = mk(0,0,0,0,  1,2,  1,0,2,0,  1,16'h0004,1);
    tbl[27] = mk(0,0,0,0,  1,2,  1,0,2,0,  0,16'h0000,1);
    tbl[28] = mk(0,1,1,2,  0,0,  0,0,0,0,  0,16'h0004,1);
    tbl[29] = mk(0,1,1,5,  0,0,  0,0,0,0,  0,16'h0024,1);
    tbl[30] = mk(1,0,0,0,  0,0,  1,1,0,5,  1,16'h0000,1);
    tbl[31] = mk(0,0,0,0,  0,0,  1,1,2,5,  0,16'h0000,1);
    tbl[32] = mk(1,1,1,3,  0,0,  0,0,0,0,  0,16'h0000,1);
    tbl[33] = mk(0,0,0,0,  0,0,  1,0,3,0,  0,16'h0000,1);

    // Reset held with random inputs
    rst = 1'b0;
    drive(idle);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      clear = 1'($urandom); issue = 1'($urandom); issueWritebackEnabled = 1'($urandom);
      issueDestination = 4'($urandom); writebackEnabled = 1'($urandom);
      writebackDestination = 4'($urandom); srcValid = 1'b1; twoSrc = 1'($urandom);
      src1 = 4'($urandom); src2 = 4'($urandom);
      #1 check("rst.hazard", 32'(hazard), 32'd0);
      check("rst.pendingMask", 32'(pendingMask), 32'd0);
      check("rst.error", 32'(error), 32'd0);
    end
    drive(idle);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    apply(idle, "post_rst");

    for (int k = 0; k < 34; k++) apply(tbl[k], $sformatf("vec%0d", k));

    // Async reset pulse mid-cycle with a pending write
    apply(mk(0,1,1,4, 0,0, 0,0,0,0, 0,16'h0010,1), "pre_arst");
    drive(mk(0,0,0,0, 0,0, 1,0,4,0, 0,0,0));
    #1 check("pre_arst.hazard", 32'(hazard), 32'd1);
    #1 rst = 1'b0;
    #1;
    check("arst.pendingMask", 32'(pendingMask), 32'd0);
    check("arst.hazard", 32'(hazard), 32'd0);
    check("arst.error", 32'(error), 32'd0);
    issue = 1'b1; issueWritebackEnabled = 1'b1; issueDestination = 4'd4;
    @(posedge clk); #1;
    check("arst_hold.pendingMask", 32'(pendingMask), 32'd0);
    drive(idle);
    #2 rst = 1'b1;
    @(posedge clk); #1;

    // Randomized traffic against the reference model
    m_reset();
    for (int c = 0; c < 600; c++) begin
      logic [15:0] exp_pm;
      bit exp_hz;
      if (c % 150 == 149) begin
        drive(idle);
        #2 rst = 1'b0;
        #1 check("rnd_arst.pendingMask", 32'(pendingMask), 32'd0);
        #1 rst = 1'b1;
        m_reset();
        @(posedge clk); #1;
        continue;
      end
      rv = idle;
      rv.clr  = ($urandom_range(0, 39) == 0);
      rv.iss  = 1'($urandom);
      rv.iwe  = ($urandom_range(0, 3) != 0);
      rv.idst = 4'($urandom);
      rv.we   = 1'($urandom);
      rv.wdst = ($urandom_range(0, 1) == 0) ? 4'($urandom) : rv.idst;
      rv.sv   = ($urandom_range(0, 3) != 0);
      rv.two  = 1'($urandom);
      rv.s1   = 4'($urandom);
      rv.s2   = 4'($urandom);
      exp_hz = rv.sv && (m_busy(int'(rv.s1), rv.we, int'(rv.wdst)) ||
                         (rv.two && m_busy(int'(rv.s2), rv.we, int'(rv.wdst))));
      m_update(rv);
      exp_pm = m_mask();
      rv.hz = exp_hz; rv.pm = exp_pm; rv.err = merr;
      apply(rv, $sformatf("rnd%0d", c));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Produces the hazard signal consumed by the instruction decode stage.
- Tracks, per architectural register, how many issued instructions have a register write still in flight between decode and writeback.
- Issue events come from the decode side. Retire events come from the writeback side.
- Stalls decode while any needed source register has a pending write that is not retiring this cycle.

Parameters:
- NUM_REGS, 16, number of architectural registers tracked; register indices are 4 bits.
- CNT_WIDTH, 2, width of each pending-write counter; max count is 2^CNT_WIDTH-1 = 3, which covers the EXE, MEM and WB slots.
- PC_REG, 15, register index excluded from tracking; it is never pending and never hazards.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  reset, asynchronous, active-low; 0 clears all state immediately.
- clear  input  1  synchronous clear of all counters, used on full pipeline flush.
- src1  input  4  first source register of the instruction in decode.
- src2  input  4  second source register of the instruction in decode.
- twoSrc  input  1  src2 is a real operand.
- srcValid  input  1  decode holds a valid, non-bubble instruction.
- issue  input  1  decode instruction advances into EXE this cycle; pre-qualified by the decode side as not hazard and not freeze.
- issueWritebackEnabled  input  1  the issuing instruction writes a register.
- issueDestination  input  4  destination register of the issuing instruction.
- writebackEnabled  input  1  writeback stage writes the register file this cycle.
- writebackDestination  input  4  register being written back.
- hazard  output  1  stall request to fetch/decode; combinational.
- pendingMask  output  16  bit i = 1 iff counter i != 0; registered.
- error  output  1  sticky flag for counter overflow or underflow; registered.

Behaviour:
- State:
  - cnt[0..NUM_REGS-1], each CNT_WIDTH bits.
  - error, sticky.
- Reset:
  - Asserted when rst=0, asynchronously.
  - All cnt = 0, pendingMask = 16'h0000, error = 0.
  - hazard = 0 whenever all counters are 0.
  - Reset asserted mid-operation discards all in-flight counts.
- Per-cycle events on a register r (r != PC_REG):
  - inc(r) = issue & issueWritebackEnabled & (issueDestination == r).
  - dec(r) = writebackEnabled & (writebackDestination == r).
- Counter update at rising clk, priority order:
  1. clear: all cnt = 0. error is unchanged.
  2. inc & dec on the same register: cnt unchanged.
  3. inc only: if cnt == max, cnt holds and error is set; else cnt + 1.
  4. dec only: if cnt == 0, cnt holds and error is set; else cnt - 1.
- Events addressed to PC_REG are ignored and never set error.
- error clears only on reset.
- pendingMask reflects the counter values after the update, i.e. it is visible one cycle after the event.
- hazard is combinational from the current counters and the current inputs:
  - eff(r) = cnt[r] - (dec(r) ? 1 : 0), floored at 0. This is the retire bypass: the register file writes on the falling edge, so decode reads the retiring value in the same cycle.
  - busy(r) = (r != PC_REG) & (eff(r) != 0).
  - hazard = srcValid & (busy(src1) | (twoSrc & busy(src2))).
  - A same-cycle issue never affects hazard.
  - clear does not mask hazard in the cycle it is asserted.
- Latency:
  - Issue at cycle N: a dependent source in decode sees hazard from cycle N+1.
  - Retire at cycle M with count 1: hazard drops in cycle M, combinationally.
- Issue while hazard=1 is a protocol violation by the upstream block. It is not checked; the counter still increments.

Test Plan:
- Reset: drive rst=0 with random inputs -> hazard=0, pendingMask=16'h0000, error=0. Release rst -> state unchanged until the first event.
- Issue with dest R3, then a decode instruction with src1=R3 -> hazard=1 from the next cycle, pendingMask=16'h0008. Writeback R3 three cycles later -> hazard=0 in that same cycle. pendingMask=16'h0000 one cycle later.
- Two in-flight writes to R5, src2=R5, twoSrc=1:
  - First retire -> hazard stays 1.
  - Second retire -> hazard=0.
  - Same instruction with twoSrc=0 -> hazard=0 throughout.
- Same-cycle issue and retire on R7 with cnt=1 -> cnt stays 1; src1=R7 gives hazard=0 in that cycle and hazard=1 the next cycle.
- Four issues to R2 with no retire -> cnt saturates at 3 and error=1. A writeback to R9 with cnt=0 -> error stays 1 and cnt[9]=0. Issue/writeback to R15 -> no change; src1=R15 -> hazard=0.
- clear with pendingMask=16'h0024 -> pendingMask=16'h0000 next cycle. Async rst=0 pulse mid-cycle with pending counts -> immediate pendingMask=0 and hazard=0.
